bitser_alu_accumulator: RTL and testbench
=========================================

// Module: bitser_alu_accumulator
// PURPOSE
//  Parametrised bit-serial accumulator with an integrated serial adder/subtractor.
//  Holds a WIDTH-bit word in a right-shift register and streams it out LSB-first.
//  Combines it with an LSB-first serial operand over WIDTH cycles per operation.
//  Sits in the bit-serial datapath after the operand shift registers.
//  Owns its own bit counter, carry flop and status flags, so the sequencer only
//  issues start/op and waits for done.
// PARAMETERS
//  WIDTH    8                 accumulator word length in bits; legal range >= 2
//  CNT_W    $clog2(WIDTH)     bit-index counter width (derived, do not override)
// PORTS
//  i_clk       in   1      clock, rising edge
//  i_rst       in   1      reset, asynchronous, active-high
//  i_start     in   1      begin operation; sampled only in IDLE
//  i_op        in   2      00 LOAD, 01 ADD, 10 SUB (acc - operand), 11 HOLD (recirculate)
//  i_clr       in   1      sync clear of acc and flags; honoured in IDLE only, i_start wins
//  i_data_in   in   1      serial operand bit, LSB first
//  o_data_out  out  1      acc[0]; old word streams out LSB-first during RUN
//  o_busy      out  1      high in RUN
//  o_done      out  1      one-cycle pulse on completion
//  o_bit_idx   out  CNT_W  index of the operand bit consumed at the next edge
//  o_carry     out  1      final carry-out (SUB: 1 = no borrow)
//  o_zero      out  1      result == 0
//  o_ovf       out  1      signed two's-complement overflow
// BEHAVIOUR
//  Reset: acc=0, state=IDLE, count=0, carry flop=0.
//    All outputs 0, except o_zero=1.
//  FSM IDLE -> RUN
//    Transition on the edge where i_start=1. At that edge:
//      op is latched; count=0; carry flop=(i_op==SUB); zero-accumulator=1.
//  FSM RUN
//    One bit per edge; at bit k, b = i_data_in (inverted for SUB).
//      LOAD:    r = b
//      HOLD:    r = acc[0]
//      ADD/SUB: r = acc[0]^b^c;  c <= maj(acc[0],b,c)
//    acc <= {r, acc[WIDTH-1:1]}; zero-accumulator &= ~r; count++.
//  FSM RUN -> IDLE
//    On the edge consuming bit WIDTH-1 (count==WIDTH-1).
//    Same edge registers o_carry, o_zero and o_ovf, and sets o_done=1 for exactly
//    one cycle; o_busy drops to 0 in that same cycle.
//  Latency: start edge N; operand bit k sampled at edge N+1+k.
//    o_done high in the cycle after edge N+WIDTH.
//  Overflow: o_ovf = carry into MSB XOR carry out of MSB (ADD/SUB only).
//  Flags for LOAD/HOLD: o_carry=0, o_ovf=0, o_zero reflects the result.
//  Flag persistence: flags hold until the next completion, i_clr or reset.
//  Busy handling: i_start, i_op and i_clr are ignored while busy; no queuing.
//  Back-to-back: i_start may be asserted in the o_done cycle.
//    The next RUN begins at the following edge, with no idle gap.
//  Reset mid-operation: async return to the reset state.
//    The partial result is discarded and no o_done is produced.
//  Bit index: o_bit_idx = count in RUN; 0 in IDLE.
//  Illegal configuration: WIDTH < 2 is rejected by an elaboration-time assertion.
// TESTING (WIDTH=8)
//  T1  reset, LOAD 0x5A
//      -> acc=0x5A; done 9 cycles after start; carry=0, ovf=0, zero=0
//  T2  acc=0x5A, ADD 0x3C
//      -> acc=0x96, carry=0, ovf=1, zero=0
//  T3  acc=0x5A, SUB 0x5A
//      -> acc=0x00, carry=1, zero=1, ovf=0
//      then SUB 0x01 -> acc=0xFF, carry=0, ovf=0
//  T4  acc=0xFF, ADD 0x01 -> acc=0x00, carry=1, zero=1, ovf=0
//      then i_start held high in the done cycle -> next RUN with no gap
//  T5  acc=0x5A, HOLD
//      -> o_data_out = 0,1,0,1,1,0,1,0 over 8 cycles; acc=0x5A at done
//  T6  assert i_rst at bit 3 of ADD
//      -> immediately busy=0, acc=0, zero=1, no done pulse
//      i_start/i_clr pulsed while busy -> no effect on the result

Source files
------------

// File: rtl/bitser_alu_accumulator.sv
// Bit-serial accumulator with integrated serial adder/subtractor.
// Holds a WIDTH-bit word, streams it LSB-first and combines it with a serial operand.
module bitser_alu_accumulator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_clr,
    input  logic             i_data_in,
    output logic             o_data_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_bit_idx,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_ovf
);

    if (WIDTH < 2) begin : g_bad_width
        $error("bitser_alu_accumulator: WIDTH must be >= 2");
    end

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             zacc_q, zacc_d;
    logic             done_q, done_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic b;
    logic r;
    logic cout;
    logic arith;

    // Bit-slice of the serial adder; SUB is acc + ~operand + 1.
    always_comb begin
        b     = i_data_in ^ (op_q == OP_SUB);
        arith = (op_q == OP_ADD) || (op_q == OP_SUB);
        cout  = (acc_q[0] & b) | (acc_q[0] & c_q) | (b & c_q);
        case (op_q)
            OP_LOAD: r = b;
            OP_HOLD: r = acc_q[0];
            default: r = acc_q[0] ^ b ^ c_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        zacc_d  = zacc_q;
        done_d  = 1'b0;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    op_d    = i_op;
                    cnt_d   = '0;
                    c_d     = (i_op == OP_SUB);
                    zacc_d  = 1'b1;
                end else if (i_clr) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    zero_d  = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                acc_d  = {r, acc_q[WIDTH-1:1]};
                zacc_d = zacc_q & ~r;
                cnt_d  = cnt_q + CNT_W'(1);
                if (arith) begin
                    c_d = cout;
                end
                // Last bit: c_q is the carry into the MSB.
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    carry_d = arith & cout;
                    ovf_d   = arith & (c_q ^ cout);
                    zero_d  = zacc_q & ~r;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            zacc_q  <= 1'b1;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            zacc_q  <= zacc_d;
            done_q  <= done_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_data_out = acc_q[0];
    assign o_busy     = (state_q == S_RUN);
    assign o_done     = done_q;
    assign o_bit_idx  = (state_q == S_RUN) ? cnt_q : '0;
    assign o_carry    = carry_q;
    assign o_zero     = zero_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_bitser_alu_accumulator.sv
// Randomised self-checking bench for bitser_alu_accumulator (WIDTH=8)
// against a word-level arithmetic reference model.
module tb_bitser_alu_accumulator;

    localparam int W = 8;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [1:0] i_op;
    logic       i_clr;
    logic       i_data_in;
    logic       o_data_out;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_bit_idx;
    logic       o_carry;
    logic       o_zero;
    logic       o_ovf;

    bitser_alu_accumulator #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_clr      (i_clr),
        .i_data_in  (i_data_in),
        .o_data_out (o_data_out),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_bit_idx  (o_bit_idx),
        .o_carry    (o_carry),
        .o_zero     (o_zero),
        .o_ovf      (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_acc;
    logic       m_c;
    logic       m_v;
    logic       m_z;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00;
        m_c   = 1'b0;
        m_v   = 1'b0;
        m_z   = 1'b1;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [7:0] d);
        logic [8:0] s;
        case (op)
            2'b00: begin
                m_acc = d;
                m_c   = 1'b0;
                m_v   = 1'b0;
            end
            2'b01: begin
                s     = {1'b0, m_acc} + {1'b0, d};
                m_c   = s[8];
                m_v   = (m_acc[7] == d[7]) && (s[7] != m_acc[7]);
                m_acc = s[7:0];
            end
            2'b10: begin
                s     = {1'b0, m_acc} + {1'b0, ~d} + 9'd1;
                m_c   = s[8];
                m_v   = (m_acc[7] != d[7]) && (s[7] != m_acc[7]);
                m_acc = s[7:0];
            end
            default: begin
                m_c = 1'b0;
                m_v = 1'b0;
            end
        endcase
        m_z = (m_acc == 8'h00);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_carry"}, 32'(o_carry), 32'(m_c));
        chk({tag, "_zero"},  32'(o_zero),  32'(m_z));
        chk({tag, "_ovf"},   32'(o_ovf),   32'(m_v));
    endtask

    task automatic idle_cycle();
        @(posedge i_clk);
        #1;
        chk("idle_done", 32'(o_done), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_idx",  32'(o_bit_idx), 32'd0);
        chk("idle_dout", 32'(o_data_out), 32'(m_acc[0]));
        chk_flags("idle");
    endtask

    // Called #1 after an edge while idle (or in the done cycle).
    task automatic run_op(input logic [1:0] op, input logic [7:0] d,
                          input bit noise);
        logic [7:0] old;
        old     = m_acc;
        i_start = 1'b1;
        i_op    = op;
        i_clr   = noise ? 1'($urandom) : 1'b0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_clr   = 1'b0;
        for (int k = 0; k < W; k++) begin
            i_data_in = d[k];
            if (noise) begin
                i_start = 1'($urandom);
                i_clr   = 1'($urandom);
                i_op    = 2'($urandom);
            end
            chk("run_busy", 32'(o_busy), 32'd1);
            chk("run_done", 32'(o_done), 32'd0);
            chk("run_idx",  32'(o_bit_idx), 32'(k));
            chk("run_dout", 32'(o_data_out), 32'(old[k]));
            @(posedge i_clk);
            #1;
        end
        i_start = 1'b0;
        i_clr   = 1'b0;
        model_op(op, d);
        chk("end_done", 32'(o_done), 32'd1);
        chk("end_busy", 32'(o_busy), 32'd0);
        chk("end_idx",  32'(o_bit_idx), 32'd0);
        chk("end_dout", 32'(o_data_out), 32'(m_acc[0]));
        chk_flags("end");
    endtask

    initial begin
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_op      = 2'b00;
        i_clr     = 1'b0;
        i_data_in = 1'b0;
        model_reset();
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_idx",  32'(o_bit_idx), 32'd0);
        chk("rst_dout", 32'(o_data_out), 32'd0);
        chk("rst_zero", 32'(o_zero), 32'd1);
        chk("rst_carry", 32'(o_carry), 32'd0);
        chk("rst_ovf",  32'(o_ovf), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        run_op(2'b00, 8'h5A, 1'b0);
        chk("t1_flags", {29'd0, o_carry, o_ovf, o_zero}, 32'd0);
        idle_cycle();
        run_op(2'b01, 8'h3C, 1'b0);
        chk("t2_ovf", 32'(o_ovf), 32'd1);
        chk("t2_carry", 32'(o_carry), 32'd0);
        idle_cycle();
        run_op(2'b00, 8'h5A, 1'b0);
        idle_cycle();
        run_op(2'b10, 8'h5A, 1'b0);
        chk("t3_carry", 32'(o_carry), 32'd1);
        chk("t3_zero", 32'(o_zero), 32'd1);
        idle_cycle();
        run_op(2'b10, 8'h01, 1'b0);
        chk("t3b_carry", 32'(o_carry), 32'd0);
        idle_cycle();
        run_op(2'b01, 8'h01, 1'b0);
        chk("t4_carry", 32'(o_carry), 32'd1);
        chk("t4_zero", 32'(o_zero), 32'd1);
        run_op(2'b00, 8'h5A, 1'b0);
        run_op(2'b11, 8'hC3, 1'b0);
        run_op(2'b11, 8'h00, 1'b1);
        idle_cycle();

        // Reset in the middle of an ADD.
        i_start = 1'b1;
        i_op    = 2'b01;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_data_in = 1'($urandom);
            @(posedge i_clk);
            #1;
        end
        chk("mid_idx", 32'(o_bit_idx), 32'd3);
        i_rst = 1'b1;
        #1;
        model_reset();
        chk("mid_busy", 32'(o_busy), 32'd0);
        chk("mid_dout", 32'(o_data_out), 32'd0);
        chk("mid_idx0", 32'(o_bit_idx), 32'd0);
        chk_flags("mid");
        #2;
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) idle_cycle();
        run_op(2'b11, 8'h00, 1'b0);
        idle_cycle();

        // Synchronous clear in IDLE.
        run_op(2'b00, 8'h7F, 1'b0);
        run_op(2'b01, 8'h01, 1'b0);
        i_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr = 1'b0;
        model_reset();
        chk("clr_dout", 32'(o_data_out), 32'd0);
        chk_flags("clr");
        idle_cycle();
        run_op(2'b11, 8'hFF, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if (1'($urandom)) idle_cycle();
            run_op(2'($urandom), 8'($urandom), 1'($urandom));
        end
        idle_cycle();
        run_op(2'b11, 8'h00, 1'b0);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
